io_rx_port: RTL and testbench
=============================

# io_rx_port

Memory-mapped byte-input responder on the core's 16-bit address / 8-bit data bus, placed beside `ram` in `top`. Bytes from an external source (UART receiver, keypad scanner) are buffered in a small FIFO. The port drives the core's `irq_i` and `io_data_i` inputs and exposes data, status and control registers in a 4-byte address window. The core drains the FIFO through bus writes, so no read strobe is needed on the bus.

## Interface

Parameters:

- `BASE_ADDR`, 16'hFF00 — window base; must be 4-byte aligned.
- `DEPTH`, 16 — FIFO entries; power of two, 2..256.

Ports:

- `clk_i`  in  1  — single clock.
- `rst_i`  in  1  — asynchronous, active-low reset.
- `address_i`  in  16  — bus address from core.
- `data_i`  in  8  — bus write data from core.
- `we_i`  in  1  — bus write enable from core.
- `data_o`  out  8  — registered read data.
- `hit_o`  out  1  — registered window hit, aligned with `data_o`; `top` uses it to mux between `io_rx_port` and `ram` read data.
- `src_data_i`  in  8  — incoming byte.
- `src_valid_i`  in  1  — one-cycle push strobe; fire-and-forget, no backpressure.
- `irq_o`  out  1  — connects to core `irq_i`.
- `io_data_o`  out  8  — connects to core `io_data_i`; FIFO head.

## Operation

- Decode: `sel = (address_i[15:2] == BASE_ADDR[15:2])`.
- Offset `address_i[1:0]`:
  - **0 DATA**
    - Read returns the head byte and does not pop; returns 0 when empty.
    - A write of any value pops one entry; a pop while empty is ignored.
  - **1 STATUS** (read-only)
    - bit0 `not_empty`, bit1 `full`, bit2 `ovf` (sticky), bit3 `irq_en`, bits7:4 = 0.
    - Writes are ignored.
  - **2 CTRL**
    - Write: bit0 sets `irq_en`; bit1=1 clears `ovf`; bit2=1 flushes the FIFO (pointers and count to 0).
    - Read returns `{7'b0, irq_en}`.
  - **3** — reads 0, writes ignored.
- Push: `src_valid_i` while not full stores `src_data_i`. While full, the byte is dropped and `ovf` is set.
- Simultaneous push and pop:
  - Full: both happen; count unchanged; `ovf` is not set.
  - Empty: push accepted, pop ignored; count becomes 1.
- Flush in the same cycle as a push: flush wins and the byte is discarded.
- Overflow set and overflow clear in the same cycle: set wins.
- `io_data_o` is the FIFO head, combinational from storage and the read pointer; 0 when empty.
- `irq_o` = registered `irq_en & not_empty`.
- Count width is `$clog2(DEPTH)+1`. Pointers are `$clog2(DEPTH)` bits and wrap naturally.

## Timing

- Reset (asynchronous, `rst_i` low) clears:
  - outputs: `data_o`=0, `hit_o`=0, `irq_o`=0, `io_data_o`=0;
  - state: count, pointers, `ovf` and `irq_en` all 0.
- Read latency is 1 cycle. An address presented in cycle N yields `data_o` and `hit_o` at the edge ending N, matching `ram`.
- Writes take effect at the edge ending the cycle in which `we_i` and `sel` are both high. STATUS and `io_data_o` reflect the change from the next cycle.
- Push at edge E:
  - `not_empty` visible in STATUS reads presented after E;
  - `irq_o` rises 1 cycle after E.
- Pop of the last entry at edge E: `irq_o` falls 1 cycle after E.
- `data_o` and `hit_o` update every cycle: `hit_o`=0 and `data_o`=0 when not selected.

## Configuration

- Macro: `IO_RX_PORT_IRQ_EN`.
- Defined: interrupt logic as described above.
- Undefined:
  - `irq_o` is tied 0;
  - the `irq_en` register is removed, so CTRL bit0 writes are ignored and STATUS bit3 and CTRL reads return 0;
  - the core polls STATUS.

## Structure

- Package `io_pkg`:
  - register offsets `IO_OFF_DATA`, `IO_OFF_STATUS`, `IO_OFF_CTRL`;
  - STATUS bit indices;
  - CTRL bit indices.
- Sub-module `io_fifo`: parameterised synchronous FIFO with push, pop, flush, head, count, full and empty. The register decode, overflow, IRQ and read mux stay in `io_rx_port`.

## Test plan

- **Reset and idle.** Hold `rst_i` low mid-run after pushes, then release.
  - Required: all outputs 0; STATUS reads 8'h00; `hit_o`=0 for address 16'h0010.
- **Push, read, pop.** With `irq_en`=1, push 8'hA5.
  - Required: `irq_o`=1 one cycle later.
  - Read FF00: returns A5; repeated reads still A5.
  - Write FF00: `irq_o`=0 one cycle later; the next FF00 read returns 00.
- **Fill and overflow.** Push 17 bytes 8'h01..8'h11 with `DEPTH`=16.
  - Required: STATUS = 8'h07 (full, overflow, not_empty).
  - 16 pops yield 01..10.
  - Write CTRL 8'h02: STATUS = 8'h00.
- **Simultaneous events.**
  - Push and pop in the same cycle when full: count stays 16, no overflow.
  - Same when empty: count becomes 1, head equals the pushed byte.
- **Flush and wrap.** Push/pop 40 bytes with pointers wrapping.
  - Required: order preserved.
  - CTRL 8'h04 with 5 entries queued: STATUS `not_empty`=0; `irq_o`=0 next cycle.
- **Macro off.** Build without `IO_RX_PORT_IRQ_EN` and write CTRL 8'h01.
  - Required: `irq_o` stays 0 with data queued; CTRL read returns 00.

Source files
------------

// File: rtl/io_pkg.sv
// Register map constants for the io_rx_port byte-input responder.
// Shared by the port and any software-facing models of its register window.
package io_pkg;

  localparam logic [1:0] IO_OFF_DATA   = 2'd0;
  localparam logic [1:0] IO_OFF_STATUS = 2'd1;
  localparam logic [1:0] IO_OFF_CTRL   = 2'd2;
  localparam logic [1:0] IO_OFF_RSVD   = 2'd3;

  localparam int IO_ST_NOT_EMPTY = 0;
  localparam int IO_ST_FULL      = 1;
  localparam int IO_ST_OVF       = 2;
  localparam int IO_ST_IRQ_EN    = 3;

  localparam int IO_CTRL_IRQ_EN  = 0;
  localparam int IO_CTRL_OVF_CLR = 1;
  localparam int IO_CTRL_FLUSH   = 2;

  function automatic logic [7:0] io_status(input logic not_empty,
                                           input logic full,
                                           input logic ovf,
                                           input logic irq_en);
    logic [7:0] s;
    s                  = 8'h00;
    s[IO_ST_NOT_EMPTY] = not_empty;
    s[IO_ST_FULL]      = full;
    s[IO_ST_OVF]       = ovf;
    s[IO_ST_IRQ_EN]    = irq_en;
    return s;
  endfunction

endpackage

// File: rtl/io_fifo.sv
// Synchronous power-of-two FIFO with push, pop and flush; head is 0 when empty.
// A pop on a full FIFO frees the slot a same-cycle push needs; flush overrides both.
module io_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Storage is not reset; the empty gate on head hides stale contents.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/io_rx_port.sv
// Memory-mapped byte-input port: FIFO of source bytes behind a 4-byte register window.
// Interrupt logic is present only when IO_RX_PORT_IRQ_EN is defined.
module io_rx_port
  import io_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'hFF00,
  parameter int          DEPTH     = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] address_i,
  input  logic [7:0]  data_i,
  input  logic        we_i,
  output logic [7:0]  data_o,
  output logic        hit_o,
  input  logic [7:0]  src_data_i,
  input  logic        src_valid_i,
  output logic        irq_o,
  output logic [7:0]  io_data_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          sel;
  logic [1:0]    off;
  logic          bus_wr;
  logic          pop_req;
  logic          ctrl_wr;
  logic          flush;
  logic          ovf_set;
  logic          ovf_clr;
  logic          ovf;
  logic [7:0]    head;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic [7:0]    rd_mux;
  logic          unused_bits;

  assign sel     = (address_i[15:2] == BASE_ADDR[15:2]);
  assign off     = address_i[1:0];
  assign bus_wr  = we_i & sel;
  assign pop_req = bus_wr & (off == IO_OFF_DATA);
  assign ctrl_wr = bus_wr & (off == IO_OFF_CTRL);
  assign flush   = ctrl_wr & data_i[IO_CTRL_FLUSH];
  assign ovf_clr = ctrl_wr & data_i[IO_CTRL_OVF_CLR];
  // A pop in the same cycle makes room, so a full FIFO only drops when nothing leaves.
  assign ovf_set = src_valid_i & full & ~pop_req;

  io_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (src_valid_i),
    .din   (src_data_i),
    .pop   (pop_req),
    .flush (flush),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)       ovf <= 1'b0;
    else if (ovf_set) ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

`ifdef IO_RX_PORT_IRQ_EN
  logic irq_en;
  logic irq_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      irq_en <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en <= data_i[IO_CTRL_IRQ_EN];
      irq_q <= irq_en & ~empty;
    end
  end

  assign irq_o = irq_q;
`else
  logic irq_en;

  assign irq_en = 1'b0;
  assign irq_o  = 1'b0;
`endif

  always_comb begin
    rd_mux = 8'h00;
    case (off)
      IO_OFF_DATA:   rd_mux = head;
      IO_OFF_STATUS: rd_mux = io_status(~empty, full, ovf, irq_en);
      IO_OFF_CTRL:   rd_mux = {7'b0, irq_en};
      default:       rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      data_o <= 8'h00;
      hit_o  <= 1'b0;
    end else begin
      hit_o  <= sel;
      data_o <= sel ? rd_mux : 8'h00;
    end
  end

  assign io_data_o = head;

  // Upper CTRL bits and the occupancy count have no reader in this block.
  assign unused_bits = ^{data_i, count};

endmodule

// File: tb/tb_io_rx_port.sv
// Self-checking bench for io_rx_port against a queue-based model of the register window.
// Expected IRQ behaviour follows whether IO_RX_PORT_IRQ_EN is defined for the build.
module tb_io_rx_port;

  localparam logic [15:0] BASE  = 16'hFF00;
  localparam logic [15:0] IDLE  = 16'h0010;
  localparam int          DEPTH = 16;
`ifdef IO_RX_PORT_IRQ_EN
  localparam bit IRQ_BUILD = 1'b1;
`else
  localparam bit IRQ_BUILD = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [15:0] address_i;
  logic [7:0]  data_i;
  logic        we_i;
  logic [7:0]  data_o;
  logic        hit_o;
  logic [7:0]  src_data_i;
  logic        src_valid_i;
  logic        irq_o;
  logic [7:0]  io_data_o;

  io_rx_port #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .address_i   (address_i),
    .data_i      (data_i),
    .we_i        (we_i),
    .data_o      (data_o),
    .hit_o       (hit_o),
    .src_data_i  (src_data_i),
    .src_valid_i (src_valid_i),
    .irq_o       (irq_o),
    .io_data_o   (io_data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: byte queue plus sticky overflow and interrupt enable.
  logic [7:0] mq[$];
  bit         m_ovf;
  bit         m_irq_en;

  logic [7:0] exp_data;
  bit         exp_hit;
  bit         exp_irq;
  logic [7:0] exp_head;

  function automatic logic [7:0] m_read(input logic [1:0] off);
    logic [7:0] r;
    r = 8'h00;
    case (off)
      2'd0: r = (mq.size() != 0) ? mq[0] : 8'h00;
      2'd1: r = {4'b0, m_irq_en, m_ovf, (mq.size() == DEPTH), (mq.size() != 0)};
      2'd2: r = {7'b0, m_irq_en};
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Drive one bus/source cycle and advance the model; sampling happens at edge + 1.
  task automatic cycle(input bit v, input logic [7:0] b, input logic [15:0] addr,
                       input bit we, input logic [7:0] wd);
    bit sel, pop_req, ctrl_wr, pre_full, popped, pushed;
    logic [1:0] off;
    src_valid_i = v; src_data_i = b; address_i = addr; we_i = we; data_i = wd;
    sel      = (addr[15:2] == BASE[15:2]);
    off      = addr[1:0];
    exp_hit  = sel;
    exp_data = sel ? m_read(off) : 8'h00;
    exp_irq  = m_irq_en && (mq.size() != 0);
    pop_req  = we && sel && (off == 2'd0);
    ctrl_wr  = we && sel && (off == 2'd2);
    pre_full = (mq.size() == DEPTH);
    if (ctrl_wr && wd[2]) begin
      mq.delete();
    end else begin
      popped = pop_req && (mq.size() != 0);
      pushed = v && ((mq.size() < DEPTH) || popped);
      if (popped) void'(mq.pop_front());
      if (pushed) mq.push_back(b);
    end
    if (v && pre_full && !pop_req)  m_ovf = 1'b1;
    else if (ctrl_wr && wd[1])      m_ovf = 1'b0;
    if (ctrl_wr) m_irq_en = IRQ_BUILD && wd[0];
    exp_head = (mq.size() != 0) ? mq[0] : 8'h00;
    @(posedge clk);
    #1;
    src_valid_i = 1'b0; we_i = 1'b0; address_i = IDLE; data_i = 8'h00;
  endtask

  task automatic idle();
    cycle(1'b0, 8'h00, IDLE, 1'b0, 8'h00);
  endtask

  task automatic push(input logic [7:0] b);
    cycle(1'b1, b, IDLE, 1'b0, 8'h00);
  endtask

  task automatic rd(input logic [1:0] off);
    cycle(1'b0, 8'h00, BASE | {14'b0, off}, 1'b0, 8'h00);
  endtask

  task automatic wr(input logic [1:0] off, input logic [7:0] d);
    cycle(1'b0, 8'h00, BASE | {14'b0, off}, 1'b1, d);
  endtask

  task automatic test_reset();
    push(8'($urandom));
    push(8'($urandom));
    #2 rst_n = 1'b0;
    #1;
    mq.delete(); m_ovf = 1'b0; m_irq_en = 1'b0;
    total++;
    if (data_o !== 8'h00 || hit_o !== 1'b0 || irq_o !== 1'b0 || io_data_o !== 8'h00) begin
      bad++;
      $display("FAIL reset_outputs got data=%h hit=%b irq=%b io=%h want all 0",
               data_o, hit_o, irq_o, io_data_o);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle();
    rd(2'd1);
    total++;
    if (data_o !== 8'h00 || hit_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_status got=%h hit=%b want=00 hit=1", data_o, hit_o);
    end
    cycle(1'b0, 8'h00, 16'h0010, 1'b0, 8'h00);
    total++;
    if (hit_o !== 1'b0 || data_o !== 8'h00 || io_data_o !== 8'h00) begin
      bad++;
      $display("FAIL reset_unselected got hit=%b data=%h io=%h want 0 00 00",
               hit_o, data_o, io_data_o);
    end
  endtask

  task automatic test_push_read_pop();
    wr(2'd2, 8'h01);
    push(8'hA5);
    total++;
    if (irq_o !== 1'b0) begin
      bad++;
      $display("FAIL irq_early got=%b want=0", irq_o);
    end
    idle();
    total++;
    if (irq_o !== IRQ_BUILD || io_data_o !== 8'hA5) begin
      bad++;
      $display("FAIL irq_rise got irq=%b io=%h want irq=%b io=a5", irq_o, io_data_o, IRQ_BUILD);
    end
    for (int i = 0; i < 2; i++) begin
      rd(2'd0);
      total++;
      if (data_o !== 8'hA5 || data_o !== exp_data) begin
        bad++;
        $display("FAIL read_head[%0d] got=%h want=a5", i, data_o);
      end
    end
    wr(2'd0, 8'($urandom));
    idle();
    total++;
    if (irq_o !== 1'b0) begin
      bad++;
      $display("FAIL irq_fall got=%b want=0", irq_o);
    end
    rd(2'd0);
    total++;
    if (data_o !== 8'h00) begin
      bad++;
      $display("FAIL read_empty got=%h want=00", data_o);
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 17; i++) push(8'(i));
    rd(2'd1);
    total++;
    if (data_o !== (IRQ_BUILD ? 8'h0F : 8'h07) || data_o !== exp_data) begin
      bad++;
      $display("FAIL fill_status got=%h want=%h", data_o, IRQ_BUILD ? 8'h0F : 8'h07);
    end
    for (int i = 1; i <= 16; i++) begin
      rd(2'd0);
      total++;
      if (data_o !== 8'(i)) begin
        bad++;
        $display("FAIL fill_order[%0d] got=%h want=%h", i, data_o, 8'(i));
      end
      wr(2'd0, 8'h00);
    end
    wr(2'd2, 8'h02);
    rd(2'd1);
    total++;
    if (data_o !== 8'h00) begin
      bad++;
      $display("FAIL ovf_clear got=%h want=00", data_o);
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] y;
    for (int i = 0; i < DEPTH; i++) push(8'($urandom));
    cycle(1'b1, 8'($urandom), BASE, 1'b1, 8'h00);
    rd(2'd1);
    total++;
    if (data_o !== 8'h03 || data_o !== exp_data) begin
      bad++;
      $display("FAIL full_pushpop_status got=%h want=03", data_o);
    end
    for (int i = 0; i < DEPTH; i++) begin
      rd(2'd0);
      total++;
      if (data_o !== exp_data) begin
        bad++;
        $display("FAIL full_pushpop_drain[%0d] got=%h want=%h", i, data_o, exp_data);
      end
      wr(2'd0, 8'h00);
    end
    rd(2'd1);
    total++;
    if (data_o !== 8'h00) begin
      bad++;
      $display("FAIL drain_count got=%h want=00", data_o);
    end
    y = 8'($urandom);
    cycle(1'b1, y, BASE, 1'b1, 8'h00);
    rd(2'd1);
    total++;
    if (data_o !== 8'h01 || io_data_o !== y) begin
      bad++;
      $display("FAIL empty_pushpop got status=%h head=%h want 01 %h", data_o, io_data_o, y);
    end
    wr(2'd0, 8'h00);
  endtask

  task automatic test_flush_wrap();
    logic [7:0] sent[$];
    int n_pushed, n_popped, iter;
    wr(2'd2, 8'h01);
    n_pushed = 0; n_popped = 0; iter = 0;
    while ((n_pushed < 40 || mq.size() != 0) && iter < 400) begin
      iter++;
      if (n_pushed < 40 && mq.size() < DEPTH && (mq.size() == 0 || $urandom_range(0, 2) != 0)) begin
        sent.push_back(8'($urandom));
        push(sent[n_pushed]);
        n_pushed++;
      end else begin
        rd(2'd0);
        total++;
        if (data_o !== sent[n_popped] || data_o !== exp_data) begin
          bad++;
          $display("FAIL wrap_order[%0d] got=%h want=%h", n_popped, data_o, sent[n_popped]);
        end
        wr(2'd0, 8'h00);
        n_popped++;
      end
    end
    total++;
    if (n_popped != 40) begin
      bad++;
      $display("FAIL wrap_budget popped=%0d want=40", n_popped);
    end
    for (int i = 0; i < 5; i++) push(8'($urandom));
    idle();
    total++;
    if (irq_o !== IRQ_BUILD) begin
      bad++;
      $display("FAIL flush_pre_irq got=%b want=%b", irq_o, IRQ_BUILD);
    end
    wr(2'd2, 8'h05);
    total++;
    if (io_data_o !== 8'h00) begin
      bad++;
      $display("FAIL flush_head got=%h want=00", io_data_o);
    end
    idle();
    total++;
    if (irq_o !== 1'b0) begin
      bad++;
      $display("FAIL flush_irq got=%b want=0", irq_o);
    end
    rd(2'd1);
    total++;
    if (data_o[0] !== 1'b0 || data_o !== exp_data) begin
      bad++;
      $display("FAIL flush_status got=%h want=%h", data_o, exp_data);
    end
    push(8'h11);
    push(8'h22);
    cycle(1'b1, 8'h33, BASE | 16'd2, 1'b1, 8'h04);
    rd(2'd1);
    total++;
    if (data_o !== 8'h00) begin
      bad++;
      $display("FAIL flush_beats_push got=%h want=00", data_o);
    end
  endtask

  task automatic test_macro_off();
    wr(2'd2, 8'h01);
    push(8'($urandom));
    idle();
    total++;
    if (irq_o !== IRQ_BUILD) begin
      bad++;
      $display("FAIL build_irq got=%b want=%b", irq_o, IRQ_BUILD);
    end
    rd(2'd2);
    total++;
    if (data_o !== {7'b0, IRQ_BUILD}) begin
      bad++;
      $display("FAIL build_ctrl_read got=%h want=%h", data_o, {7'b0, IRQ_BUILD});
    end
    wr(2'd1, 8'hFF);
    rd(2'd3);
    total++;
    if (data_o !== 8'h00 || hit_o !== 1'b1) begin
      bad++;
      $display("FAIL rsvd_read got=%h hit=%b want=00 hit=1", data_o, hit_o);
    end
    rd(2'd1);
    total++;
    if (data_o !== exp_data) begin
      bad++;
      $display("FAIL status_ro got=%h want=%h", data_o, exp_data);
    end
    wr(2'd2, 8'h06);
  endtask

  task automatic test_random();
    bit v, we;
    int op;
    logic [15:0] addr;
    logic [7:0] wd;
    for (int n = 0; n < 400; n++) begin
      v    = ($urandom_range(0, 3) != 0);
      op   = $urandom_range(0, 9);
      we   = 1'b0;
      wd   = 8'($urandom);
      addr = IDLE;
      case (op)
        0, 1: begin addr = 16'($urandom_range(0, 16'h7FFF)); we = $urandom_range(0, 1) != 0; end
        2, 3, 4: addr = BASE | 16'($urandom_range(0, 3));
        5, 6: begin addr = BASE; we = 1'b1; end
        7: begin addr = BASE | 16'd2; we = 1'b1; wd = wd & 8'h03; end
        8: begin addr = BASE | 16'($urandom_range(1, 3)); we = 1'b1; wd = wd & 8'hFB; end
        default: begin
          if ($urandom_range(0, 3) == 0) begin addr = BASE | 16'd2; we = 1'b1; wd = wd | 8'h04; v = 1'b0; end
        end
      endcase
      cycle(v, 8'($urandom), addr, we, wd);
      total++;
      if (data_o !== exp_data || hit_o !== exp_hit || irq_o !== exp_irq || io_data_o !== exp_head) begin
        bad++;
        $display("FAIL random[%0d] got data=%h hit=%b irq=%b io=%h want %h %b %b %h",
                 n, data_o, hit_o, irq_o, io_data_o, exp_data, exp_hit, exp_irq, exp_head);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; address_i = IDLE; data_i = 8'h00; we_i = 1'b0;
    src_data_i = 8'h00; src_valid_i = 1'b0;
    mq.delete(); m_ovf = 1'b0; m_irq_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_push_read_pop();
    test_fill_overflow();
    test_simultaneous();
    test_flush_wrap();
    test_macro_off();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
